qed_dup_issue: RTL and testbench

//  Issue stage that consumes QED-decoded instructions and drives the core fetch path.

---
 rtl/qed_dup_issue_if.sv | 33 +++
 rtl/qed_dup_issue.sv | 146 ++++++++++++++
 tb/tb_qed_dup_issue.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/qed_dup_issue_if.sv
// Handshake and bus bundle between fetch, the QED issue stage and the core.
// CW must equal $clog2(DEPTH+1) of the attached qed_dup_issue.
interface qed_dup_issue_if #(
  parameter int CW = 5
);
  logic          qed_ena;
  logic          exec_dup;
  logic [31:0]   ifu_qed_instruction;
  logic          ifu_vld;
  logic          ifu_rdy;
  logic          is_lw;
  logic          is_sw;
  logic          is_aluimm;
  logic          is_alureg;
  logic          core_rdy;
  logic [31:0]   qed_instruction;
  logic          qed_vld;
  logic          qed_dup_phase;
  logic [CW-1:0] dup_count;
  logic          qed_check;

  modport slave (
    input  qed_ena, exec_dup, ifu_qed_instruction, ifu_vld,
           is_lw, is_sw, is_aluimm, is_alureg, core_rdy,
    output ifu_rdy, qed_instruction, qed_vld, qed_dup_phase, dup_count, qed_check
  );

  modport master (
    output qed_ena, exec_dup, ifu_qed_instruction, ifu_vld,
           is_lw, is_sw, is_aluimm, is_alureg, core_rdy,
    input  ifu_rdy, qed_instruction, qed_vld, qed_dup_phase, dup_count, qed_check
  );
endinterface

// File: rtl/qed_dup_issue.sv
// QED issue stage: issues originals, queues remapped duplicates, replays them, pulses qed_check.
// Optional macro QED_AUTO_DUP_EN: a full duplicate FIFO forces the switch to the DUP phase.
module qed_dup_issue #(
  parameter int          DEPTH      = 16,
  parameter logic [11:0] MEM_OFFSET = 12'h400
) (
  input logic           clk,
  input logic           rst_n,
  qed_dup_issue_if.slave bus
);
  localparam int          AW  = $clog2(DEPTH);
  localparam int          CW  = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_ORIG, S_DUP, S_CHECK} state_t;

  state_t        state, state_next;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   out_instr;
  logic          out_vld;

  logic          legal, full, out_free, rdy_int, xfer_in;
  logic          push, pop, out_load, out_clear;
  logic [31:0]   dup_word, load_word;

  // Duplicates use the upper register half; x0 must stay x0 to keep its zero semantics.
  function automatic logic [4:0] remap_reg(input logic [4:0] r);
    return (r == 5'd0) ? 5'd0 : {1'b1, r[3:0]};
  endfunction

  function automatic logic [31:0] make_dup(input logic [31:0] i, input logic lw,
                                           input logic sw, input logic alureg);
    logic [31:0] d;
    logic [11:0] imm;
    d        = i;
    imm      = '0;
    d[19:15] = remap_reg(i[19:15]);
    if (sw) begin
      imm                 = {i[31:25], i[11:7]} + MEM_OFFSET;
      {d[31:25], d[11:7]} = imm;
      d[24:20]            = remap_reg(i[24:20]);
    end else begin
      d[11:7] = remap_reg(i[11:7]);
      if (lw)     d[31:20] = i[31:20] + MEM_OFFSET;
      if (alureg) d[24:20] = remap_reg(i[24:20]);
    end
    return d;
  endfunction

  assign legal     = bus.is_lw | bus.is_sw | bus.is_aluimm | bus.is_alureg;
  assign full      = (count == CW'(DEPTH));
  assign out_free  = !out_vld || bus.core_rdy;
  assign rdy_int   = (state == S_ORIG) && out_free && !full;
  assign xfer_in   = bus.qed_ena && bus.ifu_vld && rdy_int;
  assign dup_word  = make_dup(bus.ifu_qed_instruction, bus.is_lw, bus.is_sw, bus.is_alureg);
  assign load_word = pop ? mem[rd_ptr] : (legal ? bus.ifu_qed_instruction : NOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            state <= S_ORIG;
    else if (!bus.qed_ena) state <= S_ORIG;
    else                   state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_next = state;
    push       = 1'b0;
    pop        = 1'b0;
    out_load   = 1'b0;
    out_clear  = 1'b0;
    unique case (state)
      S_ORIG: begin
        if (xfer_in) begin
          out_load = 1'b1;
          push     = legal;
        end else if (out_free) begin
          out_clear = 1'b1;
        end
        if (bus.exec_dup && count != '0) state_next = S_DUP;
`ifdef QED_AUTO_DUP_EN
        if (full) state_next = S_DUP;
`else
`endif
      end
      S_DUP: begin
        // The previous entry leaves on the same edge the next one is popped into the output.
        if (out_free) begin
          if (count != '0) begin
            pop      = 1'b1;
            out_load = 1'b1;
          end else begin
            out_clear  = 1'b1;
            state_next = S_CHECK;
          end
        end
      end
      S_CHECK: state_next = S_ORIG;
      default: state_next = S_ORIG;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_vld   <= 1'b0;
      out_instr <= NOP;
    end else if (!bus.qed_ena) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_vld   <= 1'b0;
      out_instr <= NOP;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        count  <= count + CW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        count  <= count - CW'(1);
      end
      if (out_load) begin
        out_vld   <= 1'b1;
        out_instr <= load_word;
      end else if (out_clear) begin
        out_vld <= 1'b0;
      end
    end
  end

  // NOTE: the storage array is not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dup_word;
  end

  assign bus.ifu_rdy         = bus.qed_ena ? rdy_int   : bus.core_rdy;
  assign bus.qed_instruction = bus.qed_ena ? out_instr : bus.ifu_qed_instruction;
  assign bus.qed_vld         = bus.qed_ena ? out_vld   : bus.ifu_vld;
  assign bus.qed_dup_phase   = bus.qed_ena && (state == S_DUP);
  assign bus.qed_check       = bus.qed_ena && (state == S_CHECK);
  assign bus.dup_count       = count;
endmodule

// File: tb/tb_qed_dup_issue.sv
// Directed self-checking bench for qed_dup_issue (DEPTH=16, MEM_OFFSET=12'h400).
module tb_qed_dup_issue;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ADDI     = 32'h0051_0093;  // addi x1,x2,5
  localparam logic [31:0] D_ADDI   = 32'h0059_0893;
  localparam logic [31:0] LW       = 32'h0082_2183;  // lw x3,8(x4)
  localparam logic [31:0] D_LW     = 32'h408A_2983;
  localparam logic [31:0] SW       = 32'h0053_2623;  // sw x5,12(x6)
  localparam logic [31:0] D_SW     = 32'h415B_2623;
  localparam logic [31:0] ADD      = 32'h0094_03B3;  // add x7,x8,x9
  localparam logic [31:0] D_ADD    = 32'h019C_0BB3;
  localparam logic [31:0] LW_WRAP  = 32'hC000_2003;  // lw x0,-1024(x0)
  localparam logic [31:0] D_LW_WRP = 32'h0000_2003;
  localparam logic [31:0] JAL      = 32'h0000_006F;
  localparam logic [3:0]  C_LW = 4'b1000, C_SW = 4'b0100, C_AI = 4'b0010, C_AR = 4'b0001;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  qed_dup_issue_if #(.CW(5)) bus ();

  qed_dup_issue #(.DEPTH(16), .MEM_OFFSET(12'h400)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic vld, input logic [31:0] ins, input logic [3:0] cls);
    bus.ifu_vld             = vld;
    bus.ifu_qed_instruction = ins;
    {bus.is_lw, bus.is_sw, bus.is_aluimm, bus.is_alureg} = cls;
  endtask

  function automatic logic [31:0] addi_n(input int n, input bit dup);
    logic [11:0] imm;
    imm = 12'(n + 1);
    return {imm, dup ? 5'd18 : 5'd2, 3'b000, dup ? 5'd17 : 5'd1, 7'h13};
  endfunction

  // One original through ORIG, then its duplicate and the consistency pulse.
  task automatic single(input string tag, input logic [31:0] ins, input logic [3:0] cls,
                        input logic [31:0] dup);
    present(1'b1, ins, cls);
    #1 check({tag, "_rdy"}, 32'(bus.ifu_rdy), 32'd1);
    tick();
    check({tag, "_orig"}, bus.qed_instruction, ins);
    check({tag, "_orig_vld"}, 32'(bus.qed_vld), 32'd1);
    check({tag, "_cnt1"}, 32'(bus.dup_count), 32'd1);
    present(1'b0, 32'h0, 4'b0);
    bus.exec_dup = 1'b1;
    tick();
    bus.exec_dup = 1'b0;
    check({tag, "_phase"}, 32'(bus.qed_dup_phase), 32'd1);
    tick();
    check({tag, "_dup"}, bus.qed_instruction, dup);
    check({tag, "_dup_vld"}, 32'(bus.qed_vld), 32'd1);
    check({tag, "_cnt0"}, 32'(bus.dup_count), 32'd0);
    check({tag, "_dup_rdy"}, 32'(bus.ifu_rdy), 32'd0);
    tick();
    check({tag, "_check"}, 32'(bus.qed_check), 32'd1);
    check({tag, "_check_vld"}, 32'(bus.qed_vld), 32'd0);
    tick();
    check({tag, "_check_end"}, 32'(bus.qed_check), 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.qed_ena  = 1'b1;
    bus.exec_dup = 1'b0;
    bus.core_rdy = 1'b1;
    present(1'b0, 32'h0, 4'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", 32'(bus.qed_vld), 32'd0);
    check("rst_instr", bus.qed_instruction, NOP);
    check("rst_cnt", 32'(bus.dup_count), 32'd0);
    check("rst_check", 32'(bus.qed_check), 32'd0);
    check("rst_phase", 32'(bus.qed_dup_phase), 32'd0);
    rst_n = 1'b1;

    single("addi", ADDI, C_AI, D_ADDI);
    single("lw", LW, C_LW, D_LW);

    // Mixed originals incl. an illegal jal, then DUP with core back-pressure.
    present(1'b1, ADD, C_AR);
    tick();
    check("mix_add", bus.qed_instruction, ADD);
    check("mix_add_cnt", 32'(bus.dup_count), 32'd1);
    present(1'b1, JAL, 4'b0);
    tick();
    check("jal_nop", bus.qed_instruction, NOP);
    check("jal_vld", 32'(bus.qed_vld), 32'd1);
    check("jal_cnt", 32'(bus.dup_count), 32'd1);
    present(1'b1, SW, C_SW);
    tick();
    check("mix_sw", bus.qed_instruction, SW);
    present(1'b1, LW_WRAP, C_LW);
    tick();
    check("mix_lww", bus.qed_instruction, LW_WRAP);
    check("mix_cnt3", 32'(bus.dup_count), 32'd3);
    present(1'b0, 32'h0, 4'b0);
    bus.exec_dup = 1'b1;
    tick();
    bus.exec_dup = 1'b0;
    bus.core_rdy = 1'b0;
    check("mix_phase", 32'(bus.qed_dup_phase), 32'd1);
    tick();
    check("bp_dup_add", bus.qed_instruction, D_ADD);
    check("bp_cnt", 32'(bus.dup_count), 32'd2);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold", bus.qed_instruction, D_ADD);
      check("bp_hold_vld", 32'(bus.qed_vld), 32'd1);
      check("bp_hold_cnt", 32'(bus.dup_count), 32'd2);
    end
    bus.core_rdy = 1'b1;
    tick();
    check("bp_dup_sw", bus.qed_instruction, D_SW);
    tick();
    check("bp_dup_lww", bus.qed_instruction, D_LW_WRP);
    check("bp_cnt0", 32'(bus.dup_count), 32'd0);
    tick();
    check("bp_check", 32'(bus.qed_check), 32'd1);
    tick();

    // Asynchronous reset in the middle of DUP with entries still queued.
    present(1'b1, ADDI, C_AI);
    tick();
    present(1'b1, LW, C_LW);
    tick();
    present(1'b1, SW, C_SW);
    tick();
    present(1'b0, 32'h0, 4'b0);
    bus.exec_dup = 1'b1;
    tick();
    bus.exec_dup = 1'b0;
    tick();
    check("mr_phase", 32'(bus.qed_dup_phase), 32'd1);
    check("mr_cnt", 32'(bus.dup_count), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mr_vld", 32'(bus.qed_vld), 32'd0);
    check("mr_instr", bus.qed_instruction, NOP);
    check("mr_cnt0", 32'(bus.dup_count), 32'd0);
    check("mr_phase0", 32'(bus.qed_dup_phase), 32'd0);
    check("mr_check0", 32'(bus.qed_check), 32'd0);
    #2 rst_n = 1'b1;
    single("post_rst", ADDI, C_AI, D_ADDI);

    // Fill the FIFO to DEPTH.
    for (int i = 0; i < 16; i++) begin
      present(1'b1, addi_n(i, 1'b0), C_AI);
      tick();
    end
    check("full_cnt", 32'(bus.dup_count), 32'd16);
    check("full_last", bus.qed_instruction, addi_n(15, 1'b0));
    check("full_rdy", 32'(bus.ifu_rdy), 32'd0);
`ifdef QED_AUTO_DUP_EN
    tick();
    present(1'b0, 32'h0, 4'b0);
    check("auto_phase", 32'(bus.qed_dup_phase), 32'd1);
`else
    tick();
    tick();
    check("full_hold_rdy", 32'(bus.ifu_rdy), 32'd0);
    check("full_hold_cnt", 32'(bus.dup_count), 32'd16);
    check("full_hold_phase", 32'(bus.qed_dup_phase), 32'd0);
    present(1'b0, 32'h0, 4'b0);
    bus.exec_dup = 1'b1;
    tick();
    bus.exec_dup = 1'b0;
    check("full_phase", 32'(bus.qed_dup_phase), 32'd1);
`endif
    for (int i = 0; i < 16; i++) begin
      tick();
      check("full_dup", bus.qed_instruction, addi_n(i, 1'b1));
      check("full_dup_vld", 32'(bus.qed_vld), 32'd1);
    end
    tick();
    check("full_check", 32'(bus.qed_check), 32'd1);
    tick();

    // qed_ena=0: transparent path and FIFO flush.
    present(1'b1, ADDI, C_AI);
    tick();
    check("ena_cnt1", 32'(bus.dup_count), 32'd1);
    bus.qed_ena  = 1'b0;
    bus.core_rdy = 1'b0;
    present(1'b1, SW, C_SW);
    #1;
    check("pt_instr", bus.qed_instruction, SW);
    check("pt_vld", 32'(bus.qed_vld), 32'd1);
    check("pt_rdy0", 32'(bus.ifu_rdy), 32'd0);
    bus.core_rdy = 1'b1;
    #1;
    check("pt_rdy1", 32'(bus.ifu_rdy), 32'd1);
    tick();
    check("pt_flush", 32'(bus.dup_count), 32'd0);
    check("pt_check", 32'(bus.qed_check), 32'd0);
    bus.qed_ena = 1'b1;
    present(1'b0, 32'h0, 4'b0);
    #1;
    check("reena_vld", 32'(bus.qed_vld), 32'd0);
    check("reena_instr", bus.qed_instruction, NOP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
